// File: rtl/external_bus_interface.sv
// external_bus_interface
//   Bridges the CPU's internal buses to a simple req/ack external memory port.
//   ABL/ABH/DOR are loaded from the internal buses while idle. A cycle_start
//   launches one transfer. stall holds the CPU until mem_ack arrives. Read data
//   is captured into the data latch (DL), which can be driven back onto the
//   wired-AND internal buses.
//
//   Optional feature: define BUS_TIMEOUT_EN to enable a wait-cycle watchdog.
//   It aborts a transfer after TIMEOUT_CYCLES WAIT cycles without an ack. On a
//   read, DL is then forced to 8'hFF, and timeout_flag stays set until reset.
//   Without the macro the transfer waits forever and timeout_flag is tied to 0.
//
// Ports
//   clk, rst                              clock, async active-high reset
//   ADL_ABL, ADH_ABH, DB_DOR              register load strobes (IDLE only)
//   DL_DB, DL_ADL, DL_ADH                 drive DL onto DB/ADL/ADH
//   cycle_start, rw_req                   start strobe, 1=read 0=write
//   DB/ADL/ADH_toModules                  resolved internal bus values
//   DB/ADL/ADH_fromModules                wired-AND contributions (FF = idle)
//   mem_addr, mem_wdata, mem_rw, mem_req  external request side
//   mem_ack, mem_rdata                    external response side
//   stall, timeout_flag                   CPU hold, sticky abort indicator
module external_bus_interface #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ADL_ABL,
  input  logic        ADH_ABH,
  input  logic        DB_DOR,
  input  logic        DL_DB,
  input  logic        DL_ADL,
  input  logic        DL_ADH,
  input  logic        cycle_start,
  input  logic        rw_req,
  input  logic [7:0]  DB_toModules,
  input  logic [7:0]  ADL_toModules,
  input  logic [7:0]  ADH_toModules,
  output logic [7:0]  DB_fromModules,
  output logic [7:0]  ADL_fromModules,
  output logic [7:0]  ADH_fromModules,
  output logic [15:0] mem_addr,
  output logic [7:0]  mem_wdata,
  output logic        mem_rw,
  output logic        mem_req,
  input  logic        mem_ack,
  input  logic [7:0]  mem_rdata,
  output logic        stall,
  output logic        timeout_flag
);

  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1..255");
  end

  typedef enum logic {S_IDLE = 1'b0, S_WAIT = 1'b1} state_t;

  state_t     state_q, state_d;
  logic [7:0] abl, abh, dor, dl;
  logic       start, ack_done, abort;

  assign start    = (state_q == S_IDLE) && cycle_start;
  assign ack_done = (state_q == S_WAIT) && mem_ack;

`ifdef BUS_TIMEOUT_EN
  logic [7:0] wait_cnt;
  logic       limit_hit;
  logic       tflag;

  // wait_cnt holds the number of WAIT cycles already completed without an
  // ack. The limit is therefore reached on the edge that closes WAIT cycle
  // number TIMEOUT_CYCLES. An ack on that same edge still wins.
  assign limit_hit = ({1'b0, wait_cnt} + 9'd1) == 9'(TIMEOUT_CYCLES);
  assign abort     = (state_q == S_WAIT) && !mem_ack && limit_hit;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wait_cnt <= 8'h00;
      tflag    <= 1'b0;
    end else begin
      if (start)
        wait_cnt <= 8'h00;
      else if (state_q == S_WAIT && !mem_ack && !limit_hit)
        wait_cnt <= wait_cnt + 8'd1;
      if (abort)
        tflag <= 1'b1;
    end
  end

  assign timeout_flag = tflag;
`else
  assign abort        = 1'b0;
  assign timeout_flag = 1'b0;
`endif

  // state register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: if (cycle_start)       state_d = S_WAIT;
      S_WAIT: if (mem_ack || abort)  state_d = S_IDLE;
      default:                       state_d = S_IDLE;
    endcase
  end

  // FSM outputs
  always_comb begin
    stall = (state_q == S_WAIT);
  end

  // address/data registers and request handshake
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      abl     <= 8'h00;
      abh     <= 8'h00;
      dor     <= 8'h00;
      dl      <= 8'h00;
      mem_rw  <= 1'b1;
      mem_req <= 1'b0;
    end else begin
      // address and data are frozen for the whole transfer
      if (state_q == S_IDLE) begin
        if (ADL_ABL) abl <= ADL_toModules;
        if (ADH_ABH) abh <= ADH_toModules;
        if (DB_DOR)  dor <= DB_toModules;
      end
      if (start) begin
        mem_rw  <= rw_req;
        mem_req <= 1'b1;
      end
      if (ack_done || abort)
        mem_req <= 1'b0;
      if (ack_done && mem_rw)
        dl <= mem_rdata;
      else if (abort && mem_rw)
        dl <= 8'hFF;
    end
  end

  assign mem_addr  = {abh, abl};
  assign mem_wdata = dor;

  // 8'hFF is the wired-AND idle value: the bus ignores an undriven contributor
  assign DB_fromModules  = DL_DB  ? dl : 8'hFF;
  assign ADL_fromModules = DL_ADL ? dl : 8'hFF;
  assign ADH_fromModules = DL_ADH ? dl : 8'hFF;

endmodule

// File: tb/tb_external_bus_interface.sv
module tb_external_bus_interface;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        ADL_ABL, ADH_ABH, DB_DOR, DL_DB, DL_ADL, DL_ADH;
  logic        cycle_start, rw_req;
  logic [7:0]  DB_toModules, ADL_toModules, ADH_toModules;
  logic [7:0]  DB_fromModules, ADL_fromModules, ADH_fromModules;
  logic [15:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_rw, mem_req, mem_ack;
  logic [7:0]  mem_rdata;
  logic        stall, timeout_flag;

  always #5 clk = ~clk;

  external_bus_interface #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .rst(rst),
    .ADL_ABL(ADL_ABL), .ADH_ABH(ADH_ABH), .DB_DOR(DB_DOR),
    .DL_DB(DL_DB), .DL_ADL(DL_ADL), .DL_ADH(DL_ADH),
    .cycle_start(cycle_start), .rw_req(rw_req),
    .DB_toModules(DB_toModules), .ADL_toModules(ADL_toModules),
    .ADH_toModules(ADH_toModules),
    .DB_fromModules(DB_fromModules), .ADL_fromModules(ADL_fromModules),
    .ADH_fromModules(ADH_fromModules),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rw(mem_rw),
    .mem_req(mem_req), .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .stall(stall), .timeout_flag(timeout_flag)
  );

  typedef struct {
    logic [15:0] addr;
    logic [7:0]  wdata;
    logic        rw;
    int          stall_len;
    logic [7:0]  dl;
    logic        to;
  } exp_t;

  exp_t sbq[$];
  int total = 0;
  int bad   = 0;

  // transaction-level model of the architectural registers
  logic [7:0] m_abl = 8'h00, m_abh = 8'h00, m_dor = 8'h00, m_dl = 8'h00;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic clear_inputs();
    ADL_ABL = 0; ADH_ABH = 0; DB_DOR = 0;
    cycle_start = 0; rw_req = 0; mem_ack = 0;
  endtask

  // One complete transfer. ld bits: [0]=ABL [1]=ABH [2]=DOR.
  // delay = WAIT cycles before the ack cycle. noise = junk loads/starts in WAIT.
  // to = never ack, so the transfer must time out.
  task automatic xfer(input logic [15:0] addr, input logic [7:0] wd, input logic [7:0] rd,
                      input logic [2:0] ld, input logic rw, input int delay,
                      input logic noise, input logic to);
    exp_t e;
    int   len;
    @(negedge clk);
    ADL_ABL = ld[0]; ADL_toModules = addr[7:0];
    ADH_ABH = ld[1]; ADH_toModules = addr[15:8];
    DB_DOR  = ld[2]; DB_toModules  = wd;
    if (ld[0]) m_abl = addr[7:0];
    if (ld[1]) m_abh = addr[15:8];
    if (ld[2]) m_dor = wd;
    DL_DB  = 1'b1;
    DL_ADL = 1'($urandom_range(0, 1));
    DL_ADH = 1'($urandom_range(0, 1));
    @(negedge clk);
    ADL_ABL = 0; ADH_ABH = 0; DB_DOR = 0;
    cycle_start = 1; rw_req = rw;
    len = to ? TO : delay + 1;
    e.addr = {m_abh, m_abl}; e.wdata = m_dor; e.rw = rw; e.stall_len = len; e.to = to;
    e.dl = !rw ? m_dl : (to ? 8'hFF : rd);
    m_dl = e.dl;
    sbq.push_back(e);
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      cycle_start = noise; rw_req = ~rw;
      ADL_ABL = noise; ADL_toModules = 8'hFF;
      ADH_ABH = noise; ADH_toModules = 8'hFF;
      DB_DOR  = noise; DB_toModules  = 8'($urandom);
      mem_ack   = !to && (i == delay);
      mem_rdata = (i == delay) ? rd : 8'($urandom);
    end
    @(negedge clk);
    clear_inputs();
    // stray ack while idle must not disturb DL
    if ($urandom_range(0, 1) == 1) begin
      mem_ack = 1; mem_rdata = 8'($urandom);
      @(negedge clk);
      mem_ack = 0;
    end
  endtask

  // monitor: pops the scoreboard when a request appears, checks at completion
  initial begin
    exp_t cur;
    logic prev = 1'b0;
    logic mflag = 1'b0;
    int   cnt = 0;
    cur = '{16'h0, 8'h0, 1'b1, 0, 8'h0, 1'b0};
    forever begin
      @(posedge clk);
      #1;
      if (rst) begin
        prev = 1'b0; mflag = 1'b0;
        continue;
      end
      if (mem_req && !prev) begin
        if (sbq.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_req: got request at %h with empty scoreboard", mem_addr);
        end else begin
          cur = sbq.pop_front();
          chk("mem_addr", mem_addr, cur.addr);
          chk("mem_wdata", 16'(mem_wdata), 16'(cur.wdata));
          chk("mem_rw", 16'(mem_rw), 16'(cur.rw));
        end
        cnt = 1;
      end else if (mem_req) begin
        cnt++;
        chk("addr_hold", mem_addr, cur.addr);
      end else if (prev) begin
        if (cur.to) mflag = 1'b1;
        chk("stall_len", 16'(cnt), 16'(cur.stall_len));
        chk("db_from", 16'(DB_fromModules), 16'(DL_DB ? cur.dl : 8'hFF));
        chk("adl_from", 16'(ADL_fromModules), 16'(DL_ADL ? cur.dl : 8'hFF));
        chk("adh_from", 16'(ADH_fromModules), 16'(DL_ADH ? cur.dl : 8'hFF));
      end
      chk("stall_vs_req", 16'(stall), 16'(mem_req));
      chk("timeout_flag", 16'(timeout_flag), 16'(mflag));
      prev = mem_req;
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish, total=%0d", total);
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    rst = 1; clear_inputs();
    DL_DB = 1; DL_ADL = 0; DL_ADH = 0;
    DB_toModules = 0; ADL_toModules = 0; ADH_toModules = 0; mem_rdata = 0;
    #12;
    chk("rst_req", 16'(mem_req), 16'h0);
    chk("rst_rw", 16'(mem_rw), 16'h1);
    chk("rst_addr", mem_addr, 16'h0000);
    chk("rst_stall", 16'(stall), 16'h0);
    chk("rst_db_from", 16'(DB_fromModules), 16'h00);
    chk("rst_adl_from", 16'(ADL_fromModules), 16'hFF);
    @(negedge clk); rst = 0;

    // directed read, write with late ack, then ignored loads/starts during WAIT
    xfer(16'h1234, 8'h00, 8'hA5, 3'b011, 1'b1, 0, 1'b0, 1'b0);
    xfer(16'h0000, 8'h5A, 8'h00, 3'b100, 1'b0, 3, 1'b0, 1'b0);
    xfer(16'hBEEF, 8'h77, 8'hC3, 3'b111, 1'b1, 2, 1'b1, 1'b0);
    xfer(16'h4321, 8'h11, 8'h00, 3'b111, 1'b0, 1, 1'b1, 1'b0);

    for (int n = 0; n < 40; n++)
      xfer(16'($urandom), 8'($urandom), 8'($urandom), 3'($urandom),
           1'($urandom), int'($urandom_range(0, 3)), 1'($urandom), 1'b0);

    // reset in the middle of WAIT
    @(negedge clk);
    ADL_ABL = 1; ADL_toModules = 8'h9A; ADH_ABH = 1; ADH_toModules = 8'h55;
    DB_DOR = 1; DB_toModules = 8'h66; DL_DB = 1;
    @(negedge clk);
    ADL_ABL = 0; ADH_ABH = 0; DB_DOR = 0; cycle_start = 1; rw_req = 1;
    e = '{16'h559A, 8'h66, 1'b1, 1, 8'h00, 1'b0};
    sbq.push_back(e);
    @(negedge clk); cycle_start = 0;
    @(negedge clk);
    #2 rst = 1;
    #1;
    chk("midrst_req", 16'(mem_req), 16'h0);
    chk("midrst_stall", 16'(stall), 16'h0);
    chk("midrst_addr", mem_addr, 16'h0000);
    chk("midrst_wdata", 16'(mem_wdata), 16'h00);
    chk("midrst_rw", 16'(mem_rw), 16'h1);
    chk("midrst_dl", 16'(DB_fromModules), 16'h00);
    m_abl = 0; m_abh = 0; m_dor = 0; m_dl = 0;
    @(negedge clk); rst = 0;
    mem_ack = 1; mem_rdata = 8'hAA;
    @(negedge clk); mem_ack = 0;
    @(negedge clk);
    chk("post_rst_req", 16'(mem_req), 16'h0);
    chk("post_rst_dl", 16'(DB_fromModules), 16'h00);

    xfer(16'h2468, 8'h13, 8'h5C, 3'b111, 1'b1, 1, 1'b0, 1'b0);

`ifdef BUS_TIMEOUT_EN
    // ack on the limit cycle wins, then a real timeout on a read and a write
    xfer(16'h0F0F, 8'h00, 8'h3C, 3'b011, 1'b1, TO - 1, 1'b0, 1'b0);
    xfer(16'hABCD, 8'h00, 8'h00, 3'b011, 1'b1, 0, 1'b0, 1'b1);
    xfer(16'h1357, 8'h21, 8'h00, 3'b111, 1'b0, 0, 1'b1, 1'b1);
    xfer(16'h7777, 8'h00, 8'h99, 3'b011, 1'b1, 2, 1'b0, 1'b0);
    @(negedge clk); rst = 1;
    #1 chk("flag_cleared", 16'(timeout_flag), 16'h0);
    m_abl = 0; m_abh = 0; m_dor = 0; m_dl = 0;
    @(negedge clk); rst = 0;
`endif

    repeat (4) @(negedge clk);
    chk("sb_empty", 16'(sbq.size()), 16'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
